msrv32_pc_ctrl: RTL and testbench

Sequencer for the PC select mux and the PC register of the RV32 fetch stage. Each cycle it chooses the PC source (boot, EPC on MRET, trap vector, or next PC) and latches the mux result into the PC register when the AHB instruction bus is ready. It holds trap and MRET requests that arrive during bus stalls, and it produces flush, valid and trap-acknowledge strobes for the pipeline and the CSR unit.

---
 rtl/msrv32_pc_ctrl.sv | 160 ++++++++++++++++
 tb/tb_msrv32_pc_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_pc_ctrl.sv
// PC-select sequencer and PC register for the RV32 fetch stage.
// Optional WFI state is enabled by defining MSRV32_PC_CTRL_WFI_EN.
module msrv32_pc_ctrl #(
    parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
    parameter int unsigned BOOT_CYCLES  = 1
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        ahb_ready_in,
    input  logic        trap_req_in,
    input  logic        mret_req_in,
    input  logic        misaligned_instr_in,
`ifdef MSRV32_PC_CTRL_WFI_EN
    input  logic        wfi_req_in,
    input  logic        irq_pending_in,
`endif
    input  logic [31:0] pc_mux_in,
    output logic [1:0]  pc_src_out,
    output logic [31:0] pc_out,
    output logic        flush_out,
    output logic        instr_valid_out,
    output logic        trap_ack_out,
    output logic        mret_ack_out,
    output logic [2:0]  state_out
);

    typedef enum logic [2:0] {
        S_BOOT = 3'd0,
        S_RUN  = 3'd1,
        S_TRAP = 3'd2,
        S_MRET = 3'd3,
        S_WFI  = 3'd4
    } state_e;

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    state_e      state_q;
    logic [3:0]  boot_cnt_q;
    logic [31:0] pc_q;
    logic        trap_pend_q;
    logic        mret_pend_q;
    logic        flush_q;
    logic        trap_ack_q;
    logic        mret_ack_q;

    logic [31:0] pc_d;
    logic        trap_raw;
    logic        mret_raw;
    logic        trap_eff;
    logic        mret_eff;

    assign pc_d = {pc_mux_in[31:1], 1'b0};

    // A level request still high in the cycle its ack is visible belongs to
    // the request just served, so it is not taken a second time.
    assign trap_raw = (trap_req_in & ~trap_ack_q) | misaligned_instr_in;
    assign mret_raw = mret_req_in & ~mret_ack_q;
    assign trap_eff = trap_raw | trap_pend_q;
    assign mret_eff = mret_raw | mret_pend_q;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        pc_src_out      = 2'b11;
        instr_valid_out = 1'b0;
        case (state_q)
            S_BOOT: pc_src_out = 2'b00;
            S_RUN: begin
                pc_src_out      = 2'b11;
                instr_valid_out = 1'b1;
            end
            S_TRAP: pc_src_out = 2'b10;
            S_MRET: pc_src_out = 2'b01;
            default: pc_src_out = 2'b11;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_q     <= S_BOOT;
            boot_cnt_q  <= 4'd0;
            pc_q        <= BOOT_ADDRESS;
            trap_pend_q <= 1'b0;
            mret_pend_q <= 1'b0;
            flush_q     <= 1'b0;
            trap_ack_q  <= 1'b0;
            mret_ack_q  <= 1'b0;
        end else begin
            flush_q    <= 1'b0;
            trap_ack_q <= 1'b0;
            mret_ack_q <= 1'b0;
            if (!ahb_ready_in && trap_raw) trap_pend_q <= 1'b1;
            if (!ahb_ready_in && mret_raw) mret_pend_q <= 1'b1;

            case (state_q)
                S_BOOT: begin
                    if (ahb_ready_in) begin
                        if (boot_cnt_q >= BOOT_LAST) begin
                            pc_q    <= pc_d;
                            state_q <= S_RUN;
                        end else begin
                            boot_cnt_q <= boot_cnt_q + 4'd1;
                        end
                    end
                end
                S_RUN: begin
                    if (ahb_ready_in) pc_q <= pc_d;
                    if (trap_eff) begin
                        state_q <= S_TRAP;
                        if (mret_raw) mret_pend_q <= 1'b1;
                    end else if (mret_eff) begin
                        state_q <= S_MRET;
                    end
`ifdef MSRV32_PC_CTRL_WFI_EN
                    else if (wfi_req_in) begin
                        state_q <= S_WFI;
                    end
`endif
                end
                S_TRAP: begin
                    if (ahb_ready_in) begin
                        pc_q        <= pc_d;
                        trap_ack_q  <= 1'b1;
                        flush_q     <= 1'b1;
                        trap_pend_q <= 1'b0;
                        state_q     <= S_RUN;
                    end
                end
                S_MRET: begin
                    if (trap_eff) begin
                        state_q     <= S_TRAP;
                        mret_pend_q <= 1'b1;
                    end else if (ahb_ready_in) begin
                        pc_q        <= pc_d;
                        mret_ack_q  <= 1'b1;
                        flush_q     <= 1'b1;
                        mret_pend_q <= 1'b0;
                        state_q     <= S_RUN;
                    end
                end
`ifdef MSRV32_PC_CTRL_WFI_EN
                S_WFI: begin
                    if (irq_pending_in || trap_req_in) state_q <= S_TRAP;
                end
`endif
                default: begin
                    state_q    <= S_BOOT;
                    boot_cnt_q <= 4'd0;
                end
            endcase
        end
    end

    assign pc_out       = pc_q;
    assign flush_out    = flush_q;
    assign trap_ack_out = trap_ack_q;
    assign mret_ack_out = mret_ack_q;
    assign state_out    = state_q;

endmodule

// File: tb/tb_msrv32_pc_ctrl.sv
// Scoreboard bench for msrv32_pc_ctrl: per-cycle expectations are queued at
// drive time and compared after the following clock edge.
module tb_msrv32_pc_ctrl;

    logic        clk;
    logic        rst;
    logic        ready;
    logic        trap_req;
    logic        mret_req;
    logic        misaligned;
    logic        wfi_req;
    logic        irq_pending;
    logic [31:0] pc_mux;
    logic [1:0]  pc_src;
    logic [31:0] pc;
    logic        flush;
    logic        instr_valid;
    logic        trap_ack;
    logic        mret_ack;
    logic [2:0]  state;

    localparam logic [2:0] BOOT = 3'd0, RUN = 3'd1, TRAP = 3'd2, MRET = 3'd3, WFI = 3'd4;

    typedef struct {
        logic [2:0]  st;
        logic [31:0] pc;
        logic        fl;
        logic        ta;
        logic        ma;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   trap_acks   = 0;

    msrv32_pc_ctrl dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .ahb_ready_in         (ready),
        .trap_req_in          (trap_req),
        .mret_req_in          (mret_req),
        .misaligned_instr_in  (misaligned),
`ifdef MSRV32_PC_CTRL_WFI_EN
        .wfi_req_in           (wfi_req),
        .irq_pending_in       (irq_pending),
`endif
        .pc_mux_in            (pc_mux),
        .pc_src_out           (pc_src),
        .pc_out               (pc),
        .flush_out            (flush),
        .instr_valid_out      (instr_valid),
        .trap_ack_out         (trap_ack),
        .mret_ack_out         (mret_ack),
        .state_out            (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    function automatic logic [1:0] src_of(input logic [2:0] st);
        case (st)
            BOOT:    return 2'b00;
            MRET:    return 2'b01;
            TRAP:    return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    // Drive one cycle at the falling edge, queue the state expected after the
    // next rising edge, then compare it at the following falling edge.
    task automatic cyc(input logic r, input logic rdy, input logic tr, input logic mr,
                       input logic mis, input logic [31:0] mux, input logic [2:0] st,
                       input logic [31:0] epc, input logic fl, input logic ta,
                       input logic ma, input string name);
        exp_t e;
        rst        = r;
        ready      = rdy;
        trap_req   = tr;
        mret_req   = mr;
        misaligned = mis;
        pc_mux     = mux;
        sb.push_back('{st: st, pc: epc, fl: fl, ta: ta, ma: ma, name: name});
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        vectors++;
        if (trap_ack === 1'b1) trap_acks++;
        if (state !== e.st || pc !== e.pc || pc_src !== src_of(e.st) ||
            instr_valid !== (e.st == RUN) || flush !== e.fl ||
            trap_ack !== e.ta || mret_ack !== e.ma) begin
            miscompares++;
            $display("FAIL %s: got st=%0d pc=%h src=%b v=%b fl=%b ta=%b ma=%b, want st=%0d pc=%h src=%b v=%b fl=%b ta=%b ma=%b",
                     e.name, state, pc, pc_src, instr_valid, flush, trap_ack, mret_ack,
                     e.st, e.pc, src_of(e.st), (e.st == RUN), e.fl, e.ta, e.ma);
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++)
            cyc(1, 1, 1, 1, 0, 32'hdead_beef, BOOT, 32'h0, 0, 0, 0, "reset");
    endtask

    task automatic test_boot_run;
        cyc(0, 1, 0, 0, 0, 32'h0, RUN, 32'h0, 0, 0, 0, "boot_exit");
        for (int k = 1; k <= 16; k++)
            cyc(0, 1, 0, 0, 0, 32'(4 * k), RUN, 32'(4 * k), 0, 0, 0, "run_seq");
    endtask

    task automatic test_trap;
        cyc(0, 1, 1, 0, 0, 32'h44,  TRAP, 32'h44,  0, 0, 0, "trap_enter");
        cyc(0, 1, 0, 0, 0, 32'h100, RUN,  32'h100, 1, 1, 0, "trap_load");
        cyc(0, 1, 0, 0, 0, 32'h104, RUN,  32'h104, 0, 0, 0, "trap_pulse_end");
    endtask

    task automatic test_trap_and_mret;
        cyc(0, 1, 1, 1, 0, 32'h108, TRAP, 32'h108, 0, 0, 0, "both_trap_first");
        cyc(0, 1, 0, 0, 0, 32'h200, RUN,  32'h200, 1, 1, 0, "both_trap_load");
        cyc(0, 1, 0, 0, 0, 32'h204, MRET, 32'h204, 0, 0, 0, "both_mret_pend");
        cyc(0, 1, 0, 0, 0, 32'h44,  RUN,  32'h44,  1, 0, 1, "both_mret_load");
        cyc(0, 1, 0, 0, 0, 32'h48,  RUN,  32'h48,  0, 0, 0, "both_done");
    endtask

    task automatic test_mret_preempt;
        cyc(0, 1, 0, 1, 0, 32'h4c,  MRET, 32'h4c,  0, 0, 0, "pre_mret_enter");
        cyc(0, 1, 1, 0, 0, 32'h300, TRAP, 32'h4c,  0, 0, 0, "pre_trap_wins");
        cyc(0, 1, 0, 0, 0, 32'h300, RUN,  32'h300, 1, 1, 0, "pre_trap_load");
        cyc(0, 1, 0, 0, 0, 32'h304, MRET, 32'h304, 0, 0, 0, "pre_mret_kept");
        cyc(0, 1, 0, 0, 0, 32'h80,  RUN,  32'h80,  1, 0, 1, "pre_mret_load");
        cyc(0, 1, 0, 0, 0, 32'h84,  RUN,  32'h84,  0, 0, 0, "pre_done");
    endtask

    task automatic test_stall;
        int acks_before;
        cyc(0, 0, 0, 0, 0, 32'h555, RUN, 32'h84, 0, 0, 0, "stall_run_hold");
        cyc(0, 0, 0, 0, 0, 32'h555, RUN, 32'h84, 0, 0, 0, "stall_run_hold");
        acks_before = trap_acks;
        cyc(0, 0, 1, 0, 0, 32'h88, TRAP, 32'h84, 0, 0, 0, "stall_trap_enter");
        for (int i = 0; i < 4; i++)
            cyc(0, 0, 0, 0, 0, 32'h400, TRAP, 32'h84, 0, 0, 0, "stall_trap_hold");
        cyc(0, 1, 0, 0, 0, 32'h400, RUN, 32'h400, 1, 1, 0, "stall_trap_load");
        cyc(0, 1, 0, 0, 0, 32'h404, RUN, 32'h404, 0, 0, 0, "stall_once");
        cyc(0, 1, 0, 0, 0, 32'h408, RUN, 32'h408, 0, 0, 0, "stall_once");
        vectors++;
        if ((trap_acks - acks_before) !== 1) begin
            miscompares++;
            $display("FAIL stall_ack_count: got %0d trap acks, want 1", trap_acks - acks_before);
        end
    endtask

    task automatic test_misaligned;
        cyc(0, 1, 0, 0, 1, 32'h40d, TRAP, 32'h40c, 0, 0, 0, "mis_enter_bit0");
        cyc(0, 1, 0, 0, 0, 32'h501, RUN,  32'h500, 1, 1, 0, "mis_load_bit0");
        cyc(0, 1, 0, 0, 0, 32'h504, RUN,  32'h504, 0, 0, 0, "mis_done");
    endtask

    task automatic test_reset_mid_trap;
        cyc(0, 0, 1, 1, 0, 32'h508, TRAP, 32'h504, 0, 0, 0, "rst_trap_stall");
        cyc(1, 0, 0, 0, 0, 32'h508, BOOT, 32'h0,   0, 0, 0, "rst_mid_trap");
        cyc(0, 0, 0, 0, 0, 32'h10,  BOOT, 32'h0,   0, 0, 0, "rst_boot_stall");
        cyc(0, 1, 0, 0, 0, 32'h0,   RUN,  32'h0,   0, 0, 0, "rst_boot_exit");
        cyc(0, 1, 0, 0, 0, 32'h4,   RUN,  32'h4,   0, 0, 0, "rst_pend_clear");
        cyc(0, 1, 0, 0, 0, 32'h8,   RUN,  32'h8,   0, 0, 0, "rst_pend_clear");
    endtask

`ifdef MSRV32_PC_CTRL_WFI_EN
    task automatic test_wfi;
        wfi_req = 1'b1;
        cyc(0, 1, 0, 0, 0, 32'hc, WFI, 32'hc, 0, 0, 0, "wfi_enter");
        wfi_req = 1'b0;
        for (int i = 0; i < 10; i++)
            cyc(0, 1, 0, 0, 0, 32'(32'h700 + 4 * i), WFI, 32'hc, 0, 0, 0, "wfi_frozen");
        irq_pending = 1'b1;
        cyc(0, 1, 0, 0, 0, 32'h600, TRAP, 32'hc, 0, 0, 0, "wfi_irq_exit");
        irq_pending = 1'b0;
        cyc(0, 1, 0, 0, 0, 32'h600, RUN, 32'h600, 1, 1, 0, "wfi_trap_load");
    endtask
`endif

    initial begin
        rst         = 1'b1;
        ready       = 1'b1;
        trap_req    = 1'b0;
        mret_req    = 1'b0;
        misaligned  = 1'b0;
        wfi_req     = 1'b0;
        irq_pending = 1'b0;
        pc_mux      = 32'h0;
        @(negedge clk);
        test_reset;
        test_boot_run;
        test_trap;
        test_trap_and_mret;
        test_mret_preempt;
        test_stall;
        test_misaligned;
        test_reset_mid_trap;
`ifdef MSRV32_PC_CTRL_WFI_EN
        test_wfi;
`endif
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
